dram_page_controller: RTL
=========================

// Module: dram_page_controller
// PURPOSE
// Memory-side stage below the cache. It serves whole-page fill and writeback requests over the
// page-wide mainMemoryBus and signals completion with a one-cycle dataStrobe. Each page is split
// into pageSize word beats on a narrow word-wide DRAM port; read beats are reassembled into a page.
// PARAMETERS
// addressBusWidth  16  byte/word address width, same as the cache address.
// wordSize         8   DRAM beat width in bits.
// pageSize         4   words per page; power of 2, >=2.
// PORTS
// clk            in   1                   single clock; all state changes on posedge.
// reset          in   1                   asynchronous, active-high reset.
// mem_req        in   1                   level request from the cache (4-phase, see BEHAVIOUR).
// mem_we         in   1                   1=writeback page, 0=fetch page; sampled at accept.
// mem_addr       in   addressBusWidth     page address = mem_addr[MSB:$clog2(pageSize)]; low bits ignored.
// mainMemoryBus  inout pageSize*wordSize  page data; cache drives on writeback, this block drives on fill.
// dataStrobe     out  1                   one-cycle completion pulse.
// dram_en        out  1                   beat valid toward DRAM.
// dram_we        out  1                   beat is a write.
// dram_addr      out  addressBusWidth     {page address, beat index}.
// dram_wdata     out  wordSize            write beat data.
// dram_ready     in   1                   DRAM accepts a beat this cycle when dram_en=1.
// dram_rvalid    in   1                   read beat returning; in-order; any latency >=1.
// dram_rdata     in   wordSize            read beat data.
// BEHAVIOUR
// - Reset: state=IDLE. dataStrobe=0, dram_en=0, dram_we=0, dram_addr=0, dram_wdata=0.
//   Page buffer and counters=0. mainMemoryBus=Z.
// - Reset mid-operation aborts immediately. Read beats still in flight afterwards are ignored
//   (dram_rvalid in IDLE has no effect).
// - States: IDLE -> WB_BURST | RD_ISSUE; RD_ISSUE -> RD_DRAIN; WB_BURST/RD_DRAIN -> DONE -> RECOVER -> IDLE.
// - IDLE: on mem_req=1, latch mem_we and the page address.
//   - Writeback: also latch mainMemoryBus into the page buffer and go to WB_BURST.
//   - Fill: go to RD_ISSUE.
//   - Accept costs 1 cycle; the first beat appears the next cycle.
// - WB_BURST: dram_en=1, dram_we=1, dram_addr={page,beat}, dram_wdata=buffer word[beat].
//   - beat++ on each cycle with dram_ready=1. Word 0 goes out first (bits [wordSize-1:0]).
//   - The accept of beat pageSize-1 moves to DONE.
// - RD_ISSUE: dram_en=1, dram_we=0. issue counter advances on dram_ready. After the last issue,
//   go to RD_DRAIN (also when the final issue and the final rvalid coincide).
// - Reads are pipelined: issue and return counters are independent; up to pageSize beats in flight.
// - Each dram_rvalid writes buffer word[rcv] and increments rcv. This holds in both RD_ISSUE and RD_DRAIN.
// - RD_DRAIN: dram_en=0; go to DONE on the cycle rcv reaches pageSize (the registered count).
// - DONE (exactly 1 cycle): dataStrobe=1.
//   - Fill: mainMemoryBus driven with the buffer in this cycle only.
//   - Writeback: the bus stays Z.
// - RECOVER: wait for mem_req=0, then IDLE.
//   - A request still held high never gets a second service.
//   - The cache's one-cycle low between writeback and fill satisfies this wait.
// - Counters are $clog2(pageSize) bits wide and wrap naturally; the exit test uses the last-beat
//   compare, not the wrap.
// - mem_we and mem_addr changing after accept: ignored.
// - dram_rvalid outside RD_ISSUE/RD_DRAIN: ignored.
// - dram_en is never asserted in IDLE, DONE or RECOVER.
// - Bus contention rule: this block drives mainMemoryBus only in DONE with latched mem_we=0.
// STRUCTURE
// - CacheConfig package: add `typedef enum {MC_IDLE, MC_WB_BURST, MC_RD_ISSUE, MC_RD_DRAIN, MC_DONE, MC_RECOVER} MemCtrlState;`
//   and localparam beatBits=$clog2(pageSize). Reuse addressBusWidth, wordSize, pageSize from the package.
// - Sub-module page_assembler: pageSize x wordSize buffer.
//   - Parallel load from the bus.
//   - Indexed word write from dram_rdata.
//   - Indexed word read for dram_wdata.
// TESTING
// 1 Reset during RD_ISSUE beat 2 -> next cycle dram_en=0, bus Z, dataStrobe=0.
//   Late rvalid beats produce no strobe.
// 2 Fill at mem_addr=16'h0124, dram_ready=1, latency 3, rdata=AA,BB,CC,DD.
//   -> dram_addr 0124..0127, single strobe, bus=32'hDDCCBBAA for that cycle.
// 3 Writeback with bus=32'h44332211 and dram_ready toggling 1,0,1,0...
//   -> writes 11,22,33,44 to 0x0120..0x0123 in order, no duplicates, then strobe. Bus never driven.
// 4 mem_req held high for 5 cycles after strobe -> no new dram_en until req low for 1 cycle.
//   A following fill request then starts normally.
// 5 Back-to-back: writeback, then 1-cycle req low, then fill to the same page.
//   -> fill returns the data just written, using a DRAM model.
// 6 Latency-1 DRAM with rvalid on the last issue cycle -> strobe exactly 1 cycle after the 4th rvalid.

Source files
------------

// File: rtl/dram_page_controller_pkg.sv
// Shared geometry, FSM state type and beat helpers for the DRAM page controller.
// Imported by the controller top and its page buffer.
package dram_page_controller_pkg;

   localparam int unsigned addressBusWidth = 16;
   localparam int unsigned wordSize        = 8;
   localparam int unsigned pageSize        = 4;
   localparam int unsigned beatBits        = $clog2(pageSize);
   localparam int unsigned pageBits        = pageSize * wordSize;
   localparam int unsigned pageAddrBits    = addressBusWidth - beatBits;

   typedef enum logic [2:0] {
      MC_IDLE,
      MC_WB_BURST,
      MC_RD_ISSUE,
      MC_RD_DRAIN,
      MC_DONE,
      MC_RECOVER
   } MemCtrlState;

   function automatic logic is_last_beat(input logic [beatBits-1:0] idx);
      return idx == beatBits'(pageSize - 1);
   endfunction

   function automatic logic [beatBits-1:0] next_beat(input logic [beatBits-1:0] idx);
      return idx + beatBits'(1);
   endfunction

endpackage

// File: rtl/dram_page_controller_page_assembler.sv
// Page buffer: parallel load from the page bus, indexed word write from DRAM read beats,
// indexed word read for DRAM write beats.
module dram_page_controller_page_assembler
   import dram_page_controller_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_load,
   input  logic [pageBits-1:0] i_load_page,
   input  logic                i_wr_en,
   input  logic [beatBits-1:0] i_wr_idx,
   input  logic [wordSize-1:0] i_wr_data,
   input  logic [beatBits-1:0] i_rd_idx,
   output logic [wordSize-1:0] o_rd_data,
   output logic [pageBits-1:0] o_page
);

   logic [pageBits-1:0] r_buf;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_buf <= '0;
      end else if (i_load) begin
         r_buf <= i_load_page;
      end else if (i_wr_en) begin
         r_buf[int'(i_wr_idx) * wordSize +: wordSize] <= i_wr_data;
      end
   end

   assign o_rd_data = r_buf[int'(i_rd_idx) * wordSize +: wordSize];
   assign o_page    = r_buf;

endmodule

// File: rtl/dram_page_controller.sv
// Serves whole-page fill/writeback requests from the cache as word beats on a narrow DRAM port,
// pulsing o_data_strobe for one cycle on completion.
module dram_page_controller
   import dram_page_controller_pkg::*;
(
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_mem_req,
   input  logic                       i_mem_we,
   input  logic [addressBusWidth-1:0] i_mem_addr,
   inout  wire  [pageBits-1:0]        io_main_memory_bus,
   output logic                       o_data_strobe,
   output logic                       o_dram_en,
   output logic                       o_dram_we,
   output logic [addressBusWidth-1:0] o_dram_addr,
   output logic [wordSize-1:0]        o_dram_wdata,
   input  logic                       i_dram_ready,
   input  logic                       i_dram_rvalid,
   input  logic [wordSize-1:0]        i_dram_rdata
);

   MemCtrlState             r_state;
   logic                    r_we;
   logic [pageAddrBits-1:0] r_page_addr;
   logic [beatBits-1:0]     r_beat;
   logic [beatBits-1:0]     r_rcv;
   logic                    r_rcv_done;
   logic                    r_dram_en;
   logic                    r_dram_we;
   logic                    r_strobe;
   logic                    r_drive_bus;

   logic                    w_load;
   logic                    w_rd_wr;
   logic [wordSize-1:0]     w_wdata;
   logic [pageBits-1:0]     w_page;
   logic                    w_unused_addr;

   assign w_load  = (r_state == MC_IDLE) && i_mem_req && i_mem_we;
   // Read beats count only while a fill is collecting; stray or post-reset beats are dropped.
   assign w_rd_wr = i_dram_rvalid && !r_rcv_done &&
                    ((r_state == MC_RD_ISSUE) || (r_state == MC_RD_DRAIN));
   assign w_unused_addr = ^i_mem_addr[beatBits-1:0];

   dram_page_controller_page_assembler u_page_assembler (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_load      (w_load),
      .i_load_page (io_main_memory_bus),
      .i_wr_en     (w_rd_wr),
      .i_wr_idx    (r_rcv),
      .i_wr_data   (i_dram_rdata),
      .i_rd_idx    (r_beat),
      .o_rd_data   (w_wdata),
      .o_page      (w_page)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= MC_IDLE;
         r_we        <= 1'b0;
         r_page_addr <= '0;
         r_beat      <= '0;
         r_rcv       <= '0;
         r_rcv_done  <= 1'b0;
         r_dram_en   <= 1'b0;
         r_dram_we   <= 1'b0;
         r_strobe    <= 1'b0;
         r_drive_bus <= 1'b0;
      end else begin
         if (w_rd_wr) begin
            r_rcv <= next_beat(r_rcv);
            if (is_last_beat(r_rcv)) r_rcv_done <= 1'b1;
         end
         case (r_state)
            MC_IDLE: begin
               if (i_mem_req) begin
                  r_we        <= i_mem_we;
                  r_page_addr <= i_mem_addr[addressBusWidth-1:beatBits];
                  r_beat      <= '0;
                  r_rcv       <= '0;
                  r_rcv_done  <= 1'b0;
                  r_dram_en   <= 1'b1;
                  r_dram_we   <= i_mem_we;
                  r_state     <= i_mem_we ? MC_WB_BURST : MC_RD_ISSUE;
               end
            end
            MC_WB_BURST: begin
               if (i_dram_ready) begin
                  r_beat <= next_beat(r_beat);
                  if (is_last_beat(r_beat)) begin
                     r_dram_en <= 1'b0;
                     r_dram_we <= 1'b0;
                     r_strobe  <= 1'b1;
                     r_state   <= MC_DONE;
                  end
               end
            end
            MC_RD_ISSUE: begin
               if (i_dram_ready) begin
                  r_beat <= next_beat(r_beat);
                  if (is_last_beat(r_beat)) begin
                     r_dram_en <= 1'b0;
                     r_state   <= MC_RD_DRAIN;
                  end
               end
            end
            MC_RD_DRAIN: begin
               // Leave on the final return itself so the strobe follows it by one cycle.
               if (r_rcv_done || (w_rd_wr && is_last_beat(r_rcv))) begin
                  r_strobe    <= 1'b1;
                  r_drive_bus <= 1'b1;
                  r_state     <= MC_DONE;
               end
            end
            MC_DONE: begin
               r_strobe    <= 1'b0;
               r_drive_bus <= 1'b0;
               r_state     <= MC_RECOVER;
            end
            MC_RECOVER: begin
               if (!i_mem_req) r_state <= MC_IDLE;
            end
            default: r_state <= MC_IDLE;
         endcase
      end
   end

   assign io_main_memory_bus = r_drive_bus ? w_page : {pageBits{1'bz}};
   assign o_data_strobe      = r_strobe;
   assign o_dram_en          = r_dram_en;
   assign o_dram_we          = r_dram_we;
   assign o_dram_addr        = {r_page_addr, r_beat};
   assign o_dram_wdata       = w_wdata;

endmodule
